// File: rtl/edge_arb_pkg.sv
// Shared types and constants for the edge event arbiter.
package edge_arb_pkg;

    // Default number of monitored channels and the widest supported index.
    localparam int unsigned NUM_CH_DEF = 4;
    localparam int unsigned MAX_CH_W   = 4;

    // Channel index width for n channels, never narrower than one bit.
    function automatic int unsigned ch_w_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Event as presented in the output slot.
    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic                rising;
    } edge_evt_t;

endpackage

// File: rtl/edge_det.sv
// Single-channel edge detector; armed one cycle after reset so the
// reset-time input level never produces an event.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic a_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;
    logic armed_q;

    // Track the previous level and arm after the first post-reset edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= a_i;
            armed_q <= 1'b1;
        end
    end

    assign rise_o = armed_q & ~prev_q & a_i;
    assign fall_o = armed_q & prev_q & ~a_i;

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection feeding a one-deep pending store per channel,
// drained round-robin into a single valid/ready output slot.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = NUM_CH_DEF,
    parameter int unsigned CH_W   = ch_w_of(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] a_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic              rise_en_i,
    input  logic              fall_en_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic              evt_rising_o,
    output logic [NUM_CH-1:0] ovf_o,
    input  logic              ovf_clr_i
);

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] det;
    logic [NUM_CH-1:0] det_rise;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_det
        edge_det u_edge_det (
            .clk    (clk),
            .reset  (reset),
            .a_i    (a_i[g]),
            .rise_o (rise[g]),
            .fall_o (fall[g])
        );
    end

    assign det_rise = rise & ch_en_i & {NUM_CH{rise_en_i}};
    assign det      = det_rise | (fall & ch_en_i & {NUM_CH{fall_en_i}});

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pend_rise_q, pend_rise_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d, ovf_set;
    edge_evt_t         slot_q, slot_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   last_q, last_d;

    logic              slot_free;
    logic              grant;
    logic [CH_W-1:0]   grant_idx;
    logic [NUM_CH-1:0] grant_oh;
    logic [NUM_CH-1:0] eligible;
    int unsigned       idx;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        slot_free = !valid_q || evt_ready_i;
        eligible  = pend_q & ch_en_i;
        grant     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(last_q) + 32'd1 + k) % NUM_CH;
            if (!grant && slot_free && eligible[idx]) begin
                grant     = 1'b1;
                grant_idx = CH_W'(idx);
            end
        end
        grant_oh = grant ? (NUM_CH'(1) << grant_idx) : '0;
    end

    // Pending store: oldest event wins, a grant in the same cycle frees the entry.
    always_comb begin
        pend_d      = pend_q;
        pend_rise_d = pend_rise_q;
        ovf_set     = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!ch_en_i[i]) begin
                pend_d[i] = 1'b0;
            end else if (det[i]) begin
                if (pend_q[i] && !grant_oh[i]) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    pend_d[i]      = 1'b1;
                    pend_rise_d[i] = det_rise[i];
                end
            end else if (grant_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end
        // A new overflow beats a simultaneous clear.
        ovf_d = (ovf_clr_i ? '0 : ovf_q) | ovf_set;
    end

    // Output slot: load on grant, empty on handshake, otherwise hold.
    always_comb begin
        slot_d  = slot_q;
        valid_d = valid_q;
        last_d  = last_q;
        if (grant) begin
            valid_d       = 1'b1;
            slot_d.ch     = MAX_CH_W'(grant_idx);
            slot_d.rising = pend_rise_q[grant_idx];
            last_d        = grant_idx;
        end else if (evt_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset drops every pending and presented event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q      <= '0;
            pend_rise_q <= '0;
            ovf_q       <= '0;
            slot_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= CH_W'(NUM_CH - 1);
        end else begin
            pend_q      <= pend_d;
            pend_rise_q <= pend_rise_d;
            ovf_q       <= ovf_d;
            slot_q      <= slot_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    // Upper slot index bits are unused when CH_W is narrower than MAX_CH_W.
    logic unused_slot_ch;
    assign unused_slot_ch = ^slot_q.ch;

    assign evt_valid_o  = valid_q;
    assign evt_ch_o     = slot_q.ch[CH_W-1:0];
    assign evt_rising_o = slot_q.rising;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter with four channels.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a_i;
    logic [3:0] ch_en_i;
    logic       rise_en_i;
    logic       fall_en_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [1:0] evt_ch_o;
    logic       evt_rising_o;
    logic [3:0] ovf_o;
    logic       ovf_clr_i;

    int total = 0;
    int bad   = 0;

    edge_event_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .a_i          (a_i),
        .ch_en_i      (ch_en_i),
        .rise_en_i    (rise_en_i),
        .fall_en_i    (fall_en_i),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .evt_ch_o     (evt_ch_o),
        .evt_rising_o (evt_rising_o),
        .ovf_o        (ovf_o),
        .ovf_clr_i    (ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_evt(input string tag, input logic v, input logic [1:0] ch,
                              input logic r);
        check({tag, ".valid"}, {31'd0, evt_valid_o}, {31'd0, v});
        if (v) begin
            check({tag, ".ch"}, {30'd0, evt_ch_o}, {30'd0, ch});
            check({tag, ".rising"}, {31'd0, evt_rising_o}, {31'd0, r});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        a_i         = 4'b1111;
        ch_en_i     = 4'b1111;
        rise_en_i   = 1'b1;
        fall_en_i   = 1'b1;
        evt_ready_i = 1'b1;
        ovf_clr_i   = 1'b0;

        // Reset state with all inputs high.
        tick();
        tick();
        check("rst.valid", {31'd0, evt_valid_o}, 32'd0);
        check("rst.ch", {30'd0, evt_ch_o}, 32'd0);
        check("rst.rising", {31'd0, evt_rising_o}, 32'd0);
        check("rst.ovf", {28'd0, ovf_o}, 32'd0);

        // Release: the reset-time high level must not fire events.
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_evt("post_rst_quiet", 1'b0, 2'd0, 1'b0);
        end

        // Falling edges masked globally.
        fall_en_i = 1'b0;
        a_i       = 4'b0000;
        tick();
        tick();
        expect_evt("fall_masked", 1'b0, 2'd0, 1'b0);

        // Four simultaneous rising edges drain ch0..ch3, twice.
        for (int rep = 0; rep < 2; rep++) begin
            a_i = 4'b1111;
            tick();
            expect_evt("rr.detect", 1'b0, 2'd0, 1'b0);
            for (int c = 0; c < 4; c++) begin
                tick();
                expect_evt("rr.order", 1'b1, 2'(c), 1'b1);
            end
            tick();
            expect_evt("rr.drained", 1'b0, 2'd0, 1'b0);
            a_i = 4'b0000;
            tick();
            tick();
        end

        // Single rising edge on ch1: one-cycle latency, one cycle of valid.
        a_i = 4'b0010;
        tick();
        expect_evt("ch1.t", 1'b0, 2'd0, 1'b0);
        tick();
        expect_evt("ch1.t1", 1'b1, 2'd1, 1'b1);
        tick();
        expect_evt("ch1.t2", 1'b0, 2'd0, 1'b0);

        // Stall with ch2 toggling: edge on grant cycle loads, later edge overflows.
        evt_ready_i = 1'b0;
        fall_en_i   = 1'b1;
        a_i         = 4'b0110;
        tick();
        expect_evt("ovf.pend", 1'b0, 2'd0, 1'b0);
        a_i = 4'b0010;
        tick();
        expect_evt("ovf.grant", 1'b1, 2'd2, 1'b1);
        check("ovf.none_on_grant", {28'd0, ovf_o}, 32'd0);
        a_i = 4'b0110;
        tick();
        expect_evt("ovf.hold1", 1'b1, 2'd2, 1'b1);
        check("ovf.set", {28'd0, ovf_o}, 32'h4);
        tick();
        expect_evt("ovf.hold2", 1'b1, 2'd2, 1'b1);
        ovf_clr_i = 1'b1;
        a_i       = 4'b0010;
        tick();
        check("ovf.clr_vs_new", {28'd0, ovf_o}, 32'h4);
        tick();
        check("ovf.cleared", {28'd0, ovf_o}, 32'd0);
        ovf_clr_i   = 1'b0;
        evt_ready_i = 1'b1;
        tick();
        expect_evt("ovf.oldest_kept", 1'b1, 2'd2, 1'b0);
        tick();
        expect_evt("ovf.drained", 1'b0, 2'd0, 1'b0);

        // Falling-only mode on ch3.
        rise_en_i = 1'b0;
        a_i       = 4'b1010;
        tick();
        tick();
        expect_evt("fo.rise_masked", 1'b0, 2'd0, 1'b0);
        a_i = 4'b0010;
        tick();
        tick();
        expect_evt("fo.fall", 1'b1, 2'd3, 1'b0);
        tick();
        expect_evt("fo.single", 1'b0, 2'd0, 1'b0);
        a_i = 4'b1010;
        tick();
        tick();
        expect_evt("fo.rise_masked2", 1'b0, 2'd0, 1'b0);
        ch_en_i = 4'b0111;
        a_i     = 4'b0010;
        tick();
        tick();
        expect_evt("fo.ch_disabled", 1'b0, 2'd0, 1'b0);
        ch_en_i   = 4'b1111;
        rise_en_i = 1'b1;
        tick();

        // Reset mid-handshake with events still pending.
        evt_ready_i = 1'b0;
        a_i         = 4'b1101;
        tick();
        tick();
        expect_evt("mid.presented", 1'b1, 2'd0, 1'b1);
        reset = 1'b0;
        #1;
        check("mid.rst_valid", {31'd0, evt_valid_o}, 32'd0);
        check("mid.rst_ch", {30'd0, evt_ch_o}, 32'd0);
        check("mid.rst_rising", {31'd0, evt_rising_o}, 32'd0);
        tick();
        reset       = 1'b1;
        evt_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_evt("mid.no_replay", 1'b0, 2'd0, 1'b0);
        end

        // Recovery: round-robin restarts at ch0.
        a_i = 4'b1100;
        tick();
        tick();
        expect_evt("mid.recover", 1'b1, 2'd0, 1'b0);
        tick();
        expect_evt("mid.recover_done", 1'b0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
